// File: rtl/control_unit_pkg.sv
// Shared encodings for the YASAC control unit: FSM states, opcode map and ALU codes.
package control_unit_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_STK1  = 3'd4,
    S_STK2  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_ST   = 5'b00011;
  localparam logic [4:0] OP_JMP  = 5'b00100;
  localparam logic [4:0] OP_BRS  = 5'b00101;
  localparam logic [4:0] OP_CALL = 5'b00110;
  localparam logic [4:0] OP_RET  = 5'b00111;

  // Class prefixes: OPCODE[4] for register ALU ops, OPCODE[4:3] for immediate ALU ops
  localparam logic       OP_ALU_REG = 1'b1;
  localparam logic [1:0] OP_ALU_IMM = 2'b01;

  localparam logic [3:0] ALU_PASS_B = 4'h0;
  localparam logic [3:0] ALU_PASS_A = 4'h1;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle fetch/execute controller driving every data_unit strobe.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [4:0] OPCODE,
  input  logic [7:0] STATUS,
  input  logic [2:0] STATUS_SEL,
  output logic [3:0] ALU_OPERATION,
  output logic       INC_PROGCOUNT,
  output logic       CLR_PROGCOUNT,
  output logic       WRITE_PROGCOUNT,
  output logic       READ_PROGCOUNT,
  output logic       WRITE_INSTREG,
  output logic       WRITE_REGS,
  output logic       USE_IMMEDIATE,
  output logic       WRITE_MEM,
  output logic       READ_MEM,
  output logic       WRITE_MEMADDR,
  output logic       WRITE_STATREG,
  output logic       CLR_STATBIT,
  output logic       SET_STATBIT,
  output logic       PRESET_STACKPTR,
  output logic       INC_STACKPTR,
  output logic       DEC_STACKPTR,
  output logic       READ_STACKPTR,
  output logic       HALTED
);

  state_t state, state_next;
  logic   is_call;
  logic   branch_taken;

  assign is_call      = (OPCODE == OP_CALL);
  assign branch_taken = STATUS[STATUS_SEL];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_RESET;
    else          state <= state_next;
  end

  always_comb begin
    state_next      = state;
    ALU_OPERATION   = ALU_PASS_B;
    INC_PROGCOUNT   = 1'b0;
    CLR_PROGCOUNT   = 1'b0;
    WRITE_PROGCOUNT = 1'b0;
    READ_PROGCOUNT  = 1'b0;
    WRITE_INSTREG   = 1'b0;
    WRITE_REGS      = 1'b0;
    USE_IMMEDIATE   = 1'b0;
    WRITE_MEM       = 1'b0;
    READ_MEM        = 1'b0;
    WRITE_MEMADDR   = 1'b0;
    WRITE_STATREG   = 1'b0;
    CLR_STATBIT     = 1'b0;
    SET_STATBIT     = 1'b0;
    PRESET_STACKPTR = 1'b0;
    INC_STACKPTR    = 1'b0;
    DEC_STACKPTR    = 1'b0;
    READ_STACKPTR   = 1'b0;
    HALTED          = 1'b0;

    case (state)
      S_RESET: begin
        CLR_PROGCOUNT   = 1'b1;
        PRESET_STACKPTR = 1'b1;
        state_next      = S_FETCH;
      end
      S_FETCH: begin
        WRITE_INSTREG = 1'b1;
        INC_PROGCOUNT = 1'b1;
        state_next    = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_FETCH;
        if (OPCODE[4] == OP_ALU_REG) begin
          ALU_OPERATION = OPCODE[3:0];
          WRITE_REGS    = 1'b1;
          WRITE_STATREG = 1'b1;
        end else if (OPCODE[4:3] == OP_ALU_IMM) begin
          ALU_OPERATION = {1'b0, OPCODE[2:0]};
          USE_IMMEDIATE = 1'b1;
          WRITE_REGS    = 1'b1;
          WRITE_STATREG = 1'b1;
        end else begin
          case (OPCODE)
            OP_HALT: state_next = S_HALT;
            OP_LD, OP_ST: begin
              USE_IMMEDIATE = 1'b1;
              WRITE_MEMADDR = 1'b1;
              state_next    = S_MEM;
            end
            OP_JMP: begin
              USE_IMMEDIATE   = 1'b1;
              WRITE_PROGCOUNT = 1'b1;
            end
            OP_BRS: begin
              USE_IMMEDIATE   = branch_taken;
              WRITE_PROGCOUNT = branch_taken;
            end
            OP_CALL: begin
              READ_STACKPTR = 1'b1;
              WRITE_MEMADDR = 1'b1;
              state_next    = S_STK1;
            end
            OP_RET: begin
              INC_STACKPTR = 1'b1;
              state_next   = S_STK1;
            end
            default: state_next = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        // OPCODE[0] separates ST (1) from LD (0); only those two reach this state
        if (OPCODE[0]) begin
          ALU_OPERATION = ALU_PASS_A;
          WRITE_MEM     = 1'b1;
        end else begin
          READ_MEM   = 1'b1;
          WRITE_REGS = 1'b1;
        end
        state_next = S_FETCH;
      end
      S_STK1: begin
        if (is_call) begin
          READ_PROGCOUNT = 1'b1;
          WRITE_MEM      = 1'b1;
          DEC_STACKPTR   = 1'b1;
        end else begin
          READ_STACKPTR = 1'b1;
          WRITE_MEMADDR = 1'b1;
        end
        state_next = S_STK2;
      end
      S_STK2: begin
        if (is_call) USE_IMMEDIATE = 1'b1;
        else         READ_MEM      = 1'b1;
        WRITE_PROGCOUNT = 1'b1;
        state_next      = S_FETCH;
      end
      S_HALT: begin
        HALTED     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven check of control_unit strobe sequences per instruction class.
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [4:0] OPCODE = '0;
  logic [7:0] STATUS = '0;
  logic [2:0] STATUS_SEL = '0;
  logic [3:0] ALU_OPERATION;
  logic INC_PROGCOUNT, CLR_PROGCOUNT, WRITE_PROGCOUNT, READ_PROGCOUNT;
  logic WRITE_INSTREG, WRITE_REGS, USE_IMMEDIATE;
  logic WRITE_MEM, READ_MEM, WRITE_MEMADDR, WRITE_STATREG;
  logic CLR_STATBIT, SET_STATBIT;
  logic PRESET_STACKPTR, INC_STACKPTR, DEC_STACKPTR, READ_STACKPTR;
  logic HALTED;

  control_unit dut (
    .CLK(CLK), .RESET_N(RESET_N), .OPCODE(OPCODE), .STATUS(STATUS), .STATUS_SEL(STATUS_SEL),
    .ALU_OPERATION(ALU_OPERATION),
    .INC_PROGCOUNT(INC_PROGCOUNT), .CLR_PROGCOUNT(CLR_PROGCOUNT),
    .WRITE_PROGCOUNT(WRITE_PROGCOUNT), .READ_PROGCOUNT(READ_PROGCOUNT),
    .WRITE_INSTREG(WRITE_INSTREG), .WRITE_REGS(WRITE_REGS), .USE_IMMEDIATE(USE_IMMEDIATE),
    .WRITE_MEM(WRITE_MEM), .READ_MEM(READ_MEM), .WRITE_MEMADDR(WRITE_MEMADDR),
    .WRITE_STATREG(WRITE_STATREG), .CLR_STATBIT(CLR_STATBIT), .SET_STATBIT(SET_STATBIT),
    .PRESET_STACKPTR(PRESET_STACKPTR), .INC_STACKPTR(INC_STACKPTR),
    .DEC_STACKPTR(DEC_STACKPTR), .READ_STACKPTR(READ_STACKPTR), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  logic [21:0] word;
  assign word = {ALU_OPERATION, INC_PROGCOUNT, CLR_PROGCOUNT, WRITE_PROGCOUNT, READ_PROGCOUNT,
                 WRITE_INSTREG, WRITE_REGS, USE_IMMEDIATE, WRITE_MEM, READ_MEM, WRITE_MEMADDR,
                 WRITE_STATREG, CLR_STATBIT, SET_STATBIT, PRESET_STACKPTR, INC_STACKPTR,
                 DEC_STACKPTR, READ_STACKPTR, HALTED};

  localparam logic [21:0] B_INC_PC   = 22'h1 << 17;
  localparam logic [21:0] B_CLR_PC   = 22'h1 << 16;
  localparam logic [21:0] B_WR_PC    = 22'h1 << 15;
  localparam logic [21:0] B_RD_PC    = 22'h1 << 14;
  localparam logic [21:0] B_WR_IR    = 22'h1 << 13;
  localparam logic [21:0] B_WR_REGS  = 22'h1 << 12;
  localparam logic [21:0] B_USE_IMM  = 22'h1 << 11;
  localparam logic [21:0] B_WR_MEM   = 22'h1 << 10;
  localparam logic [21:0] B_RD_MEM   = 22'h1 << 9;
  localparam logic [21:0] B_WR_MA    = 22'h1 << 8;
  localparam logic [21:0] B_WR_STAT  = 22'h1 << 7;
  localparam logic [21:0] B_PRE_SP   = 22'h1 << 4;
  localparam logic [21:0] B_INC_SP   = 22'h1 << 3;
  localparam logic [21:0] B_DEC_SP   = 22'h1 << 2;
  localparam logic [21:0] B_RD_SP    = 22'h1 << 1;
  localparam logic [21:0] B_HALTED   = 22'h1;
  localparam logic [21:0] W_RESET    = B_CLR_PC | B_PRE_SP;
  localparam logic [21:0] W_FETCH    = B_WR_IR | B_INC_PC;

  function automatic logic [21:0] alu(input logic [3:0] op);
    return {op, 18'h0};
  endfunction

  typedef struct {
    string            name;
    logic [4:0]       opcode;
    logic [7:0]       status;
    logic [2:0]       sel;
    int unsigned      n;
    logic [2:0][21:0] exp;
  } vec_t;

  vec_t vecs[14];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [21:0] exp);
    checks++;
    if (word !== exp) begin
      failures++;
      $display("FAIL %s: got %06h expected %06h at %0t", name, word, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    vecs[0]  = '{"alu_reg_2",   5'b10010, 8'h00, 3'd0, 1, '{22'h0, 22'h0, alu(4'h2) | B_WR_REGS | B_WR_STAT}};
    vecs[1]  = '{"alu_imm_3",   5'b01011, 8'h00, 3'd0, 1, '{22'h0, 22'h0, alu(4'h3) | B_USE_IMM | B_WR_REGS | B_WR_STAT}};
    vecs[2]  = '{"alu_reg_f",   5'b11111, 8'h00, 3'd0, 1, '{22'h0, 22'h0, alu(4'hf) | B_WR_REGS | B_WR_STAT}};
    vecs[3]  = '{"alu_imm_0",   5'b01000, 8'h00, 3'd0, 1, '{22'h0, 22'h0, B_USE_IMM | B_WR_REGS | B_WR_STAT}};
    vecs[4]  = '{"nop",         5'b00000, 8'hff, 3'd0, 1, '{22'h0, 22'h0, 22'h0}};
    vecs[5]  = '{"jmp",         5'b00100, 8'h00, 3'd0, 1, '{22'h0, 22'h0, B_USE_IMM | B_WR_PC}};
    vecs[6]  = '{"brs_taken",   5'b00101, 8'h01, 3'd0, 1, '{22'h0, 22'h0, B_USE_IMM | B_WR_PC}};
    vecs[7]  = '{"brs_not",     5'b00101, 8'h01, 3'd1, 1, '{22'h0, 22'h0, 22'h0}};
    vecs[8]  = '{"brs_bit7",    5'b00101, 8'h80, 3'd7, 1, '{22'h0, 22'h0, B_USE_IMM | B_WR_PC}};
    vecs[9]  = '{"brs_bit7_no", 5'b00101, 8'h7f, 3'd7, 1, '{22'h0, 22'h0, 22'h0}};
    vecs[10] = '{"ld",          5'b00010, 8'h00, 3'd0, 2, '{22'h0, B_RD_MEM | B_WR_REGS, B_USE_IMM | B_WR_MA}};
    vecs[11] = '{"st",          5'b00011, 8'h00, 3'd0, 2, '{22'h0, alu(4'h1) | B_WR_MEM, B_USE_IMM | B_WR_MA}};
    vecs[12] = '{"call",        5'b00110, 8'h00, 3'd0, 3, '{B_USE_IMM | B_WR_PC, B_RD_PC | B_WR_MEM | B_DEC_SP, B_RD_SP | B_WR_MA}};
    vecs[13] = '{"ret",         5'b00111, 8'h00, 3'd0, 3, '{B_RD_MEM | B_WR_PC, B_RD_SP | B_WR_MA, B_INC_SP}};

    // Long reset: strobes held throughout and for one cycle after release
    RESET_N = 1'b0;
    OPCODE  = 5'b10010;
    #1 chk("reset_async", W_RESET);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", W_RESET);
    end
    RESET_N = 1'b1;
    #1 chk("reset_release", W_RESET);
    tick();
    chk("first_fetch", W_FETCH);
    tick();
    chk("first_exec", alu(4'h2) | B_WR_REGS | B_WR_STAT);
    tick();
    chk("second_fetch", W_FETCH);

    foreach (vecs[v]) begin
      RESET_N    = 1'b0;
      OPCODE     = vecs[v].opcode;
      STATUS     = vecs[v].status;
      STATUS_SEL = vecs[v].sel;
      tick();
      chk({vecs[v].name, "_rst"}, W_RESET);
      RESET_N = 1'b1;
      tick();
      chk({vecs[v].name, "_fetch"}, W_FETCH);
      for (int unsigned c = 0; c < vecs[v].n; c++) begin
        tick();
        chk($sformatf("%s_c%0d", vecs[v].name, c), vecs[v].exp[c]);
      end
      tick();
      chk({vecs[v].name, "_next_fetch"}, W_FETCH);
    end

    // HALT: no strobes in exec, then parked with only HALTED
    RESET_N = 1'b0;
    OPCODE  = 5'b00001;
    tick();
    RESET_N = 1'b1;
    tick();
    chk("halt_fetch", W_FETCH);
    tick();
    chk("halt_exec", 22'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_park", B_HALTED);
    end
    RESET_N = 1'b0;
    #1 chk("halt_exit_reset", W_RESET);

    // Reset asserted inside S_STK1 of a CALL kills WRITE_MEM at once
    OPCODE = 5'b00110;
    tick();
    RESET_N = 1'b1;
    tick();
    chk("mid_call_fetch", W_FETCH);
    tick();
    chk("mid_call_exec", B_RD_SP | B_WR_MA);
    tick();
    chk("mid_call_stk1", B_RD_PC | B_WR_MEM | B_DEC_SP);
    RESET_N = 1'b0;
    #1 chk("mid_call_abort", W_RESET);
    tick();
    chk("mid_call_hold", W_RESET);
    RESET_N = 1'b1;
    tick();
    chk("mid_call_refetch", W_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
